country_sensor_conditioner: RTL and testbench
=============================================

# country_sensor_conditioner

Conditions the raw country-road vehicle-loop detector into the clean car-waiting request `x` that feeds the highway/country traffic-light controller. It synchronises and debounces the loop signal and enforces a maximum country-green window by feeding back the controller's `country_road` lamp code. It sits directly upstream of the light controller, with `x` wired straight to that controller's `x` input.

## Interface
- `DEBOUNCE`, 4: consecutive synchronised samples (≥1) needed to assert or deassert `x`.
- `MAX_GREEN`, 16: cycles of country green with `x` high before `x` is forced low (≥1).
- `LOCKOUT`, 8: minimum cycles `x` stays forced low after a max-green cut (≥1).
- `STUCK_LIMIT`, 64: cycles of continuous raw-high before a sensor fault. Used only with the Configuration macro.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `sensor_raw`  input  1  asynchronous loop-detector level, 1 = vehicle over loop.
- `country_road`  input  2  lamp code from the controller: red=00, yellow=01, green=10.
- `x`  output  1  registered car-waiting request to the controller.
- `sensor_fault`  output  1  registered stuck-sensor flag. Tied 0 without the macro.

## Operation
- Two-flop synchroniser on `sensor_raw` produces `s`. All decisions use `s`.
- States:
  - IDLE: `x`=0.
  - ARM: qualifying high, `x`=0.
  - PRESENT: `x`=1.
  - DROP: qualifying low, `x`=1.
  - LOCKOUT: `x`=0.
- IDLE: `s`=1 → ARM, `cnt`=0.
- ARM:
  - `s`=0 → IDLE.
  - Else if `cnt`==DEBOUNCE-1 → PRESENT.
  - Else `cnt`++.
- PRESENT: `s`=0 → DROP, `cnt`=0.
- DROP:
  - `s`=1 → PRESENT.
  - Else if `cnt`==DEBOUNCE-1 → IDLE.
  - Else `cnt`++.
- `gcnt` counts cycles where `country_road`==green and state ∈ {PRESENT, DROP}.
  - Cleared whenever `country_road`≠green.
  - Saturates at MAX_GREEN-1.
- Max-green cut: in PRESENT or DROP with `gcnt`==MAX_GREEN-1 and `country_road`==green → LOCKOUT, `lcnt`=0. This takes priority over debounce transitions.
- LOCKOUT:
  - `lcnt` increments, saturating at LOCKOUT-1.
  - Exit to IDLE only when `lcnt`==LOCKOUT-1 and `country_road`≠green.
  - A car still present re-qualifies through ARM.
- Yellow (01) or red (00) on `country_road` never modifies `x`. Only green feeds `gcnt`.
- Illegal `country_road`=11 is treated as not-green.
- Counter widths: $clog2 of (largest parameter + 1). No wrap; saturate.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - Synchroniser flops, `cnt`, `gcnt`, `lcnt` = 0.
  - `x`=0, `sensor_fault`=0.
- Reset mid-operation aborts any state immediately. No output pulse on release.
- Rise latency: `sensor_raw` first sampled high at edge 0 and held → `x`=1 after edge DEBOUNCE+2.
- Fall latency: raw low held → `x`=0 after edge DEBOUNCE+2.
- Glitches shorter than DEBOUNCE synchronised cycles never change `x`.
- Max-green: `x` falls on the edge after the MAX_GREEN-th consecutive cycle of green with `x`=1.
- `x` is a direct flop output: glitch-free, exactly one transition per state change.

## Configuration
- `SENSOR_STUCK_DETECT_EN`, when defined:
  - `scnt` counts consecutive `s`=1 cycles and clears on `s`=0.
  - At `scnt`==STUCK_LIMIT-1, `sensor_fault` sets and state is forced to IDLE.
  - While `sensor_fault`=1, `x` is held 0.
  - `sensor_fault` clears, and normal operation resumes, after the first `s`=0 sample.
- Undefined: no `scnt`, and `sensor_fault` is constant 0.

## Structure
- Shared package `traffic_pkg`:
  - Lamp-code constants RED/YELLOW/GREEN (2-bit), shared with the light controller.
  - Conditioner state enum (3-bit).
- One sub-module, `sync2`: a generic two-flop synchroniser with async active-high reset, reusable for other field inputs.

## Test plan
- Reset: hold `rst`=1 with `sensor_raw`=1 → `x`=0, `sensor_fault`=0. Release → `x` rises exactly 6 edges after the first sampling edge (DEBOUNCE=4).
- Glitch rejection: 3-cycle raw high pulse, then low → `x` stays 0. 3-cycle low dip while `x`=1 → `x` stays 1.
- Normal fall: raw drops with `country_road`=red → `x` falls 6 edges later.
- Max-green:
  - Raw held high, `country_road`=green from the cycle `x` rises → `x` falls after 16 green cycles.
  - Stays 0 for ≥8 cycles, and stays 0 while green persists.
  - After `country_road`→red, `x` re-asserts after ARM (4 more edges).
- Async reset mid-DROP: assert `rst` between clock edges → `x`=0 immediately. Counters are 0 after release.
- With `SENSOR_STUCK_DETECT_EN` (STUCK_LIMIT=64): raw stuck high for 70 cycles → `sensor_fault`=1 and `x`=0. One low sample → `sensor_fault`=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country traffic-light block: lamp codes,
// conditioner state encoding and a small width helper.
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DROP    = 3'd3,
        ST_LOCKOUT = 3'd4
    } cond_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous field inputs.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/country_sensor_conditioner.sv
// Debounces the country-road loop detector into request x and cuts x after a
// maximum country-green window. Stuck-sensor detection under SENSOR_STUCK_DETECT_EN.
//
// state      | meaning
// IDLE       | no car, x=0
// ARM        | qualifying a high, x=0
// PRESENT    | car present, x=1
// DROP       | qualifying a low, x=1
// LOCKOUT    | forced low after max-green cut, x=0
module country_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned MAX_GREEN   = 16,
    parameter int unsigned LOCKOUT     = 8,
    parameter int unsigned STUCK_LIMIT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic [1:0] country_road,
    output logic       x,
    output logic       sensor_fault
);

    localparam int unsigned CW = $clog2(max4(DEBOUNCE, MAX_GREEN, LOCKOUT, STUCK_LIMIT) + 1);
    localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] GRN_TC = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] LCK_TC = CW'(LOCKOUT - 1);

    logic          s;
    logic          green;
    logic          active;
    logic          max_cut;
    cond_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] gcnt_q, gcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic          x_q, x_d;
    logic          fault_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sensor_raw),
        .q   (s)
    );

    assign green   = (country_road == GREEN);
    assign active  = (state_q == ST_PRESENT) || (state_q == ST_DROP);
    assign max_cut = active && green && (gcnt_q == GRN_TC);

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [CW-1:0] STK_TC = CW'(STUCK_LIMIT - 1);

    logic [CW-1:0] scnt_q, scnt_d;
    logic          fault_q;

    always_comb begin
        scnt_d  = scnt_q;
        fault_d = fault_q;
        if (!s) begin
            scnt_d  = '0;
            fault_d = 1'b0;
        end else begin
            if (scnt_q != STK_TC) scnt_d = scnt_q + CW'(1);
            if (scnt_q == STK_TC) fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            fault_q <= fault_d;
        end
    end

    assign sensor_fault = fault_q;
`else
    assign fault_d      = 1'b0;
    assign sensor_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (!s)                  state_d = ST_IDLE;
                else if (cnt_q == DEB_TC) state_d = ST_PRESENT;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            ST_PRESENT: begin
                if (max_cut) begin
                    state_d = ST_LOCKOUT;
                    lcnt_d  = '0;
                end else if (!s) begin
                    state_d = ST_DROP;
                    cnt_d   = '0;
                end
            end
            ST_DROP: begin
                if (max_cut) begin
                    state_d = ST_LOCKOUT;
                    lcnt_d  = '0;
                end else if (s)          state_d = ST_PRESENT;
                else if (cnt_q == DEB_TC) state_d = ST_IDLE;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            ST_LOCKOUT: begin
                if ((lcnt_q == LCK_TC) && !green) state_d = ST_IDLE;
                else if (lcnt_q != LCK_TC)        lcnt_d  = lcnt_q + CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // A latched sensor fault parks the FSM so a stuck loop cannot hold x high.
        if (fault_d) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        gcnt_d = gcnt_q;
        if (!green)                        gcnt_d = '0;
        else if (active && gcnt_q != GRN_TC) gcnt_d = gcnt_q + CW'(1);

        x_d = ((state_d == ST_PRESENT) || (state_d == ST_DROP)) && !fault_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            lcnt_q  <= '0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            lcnt_q  <= lcnt_d;
            x_q     <= x_d;
        end
    end

    assign x = x_q;

endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Self-checking bench for country_sensor_conditioner against a run-length
// reference model of the debounce, max-green and lockout rules.
module tb_country_sensor_conditioner;

    localparam int D = 4;
    localparam int M = 16;
    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_raw = 1'b0;
    logic [1:0] country_road = 2'b00;
    logic       x;
    logic       sensor_fault;

    int passed = 0;
    int total  = 0;

    // reference model state
    int m_r1, m_r2, m_x, m_run, m_g, m_lock, m_lc;

    country_sensor_conditioner #(
        .DEBOUNCE(D), .MAX_GREEN(M), .LOCKOUT(L), .STUCK_LIMIT(64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_raw   (sensor_raw),
        .country_road (country_road),
        .x            (x),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_r1 = 0; m_r2 = 0; m_x = 0; m_run = 0; m_g = 0; m_lock = 0; m_lc = 0;
    endtask

    // x toggles once s has disagreed with it for D+1 consecutive samples;
    // green cycles with x high accumulate toward the cut.
    task automatic model_step();
        int s, grn, old_x;
        if (rst) begin
            m_reset();
            return;
        end
        s     = m_r2;
        m_r2  = m_r1;
        m_r1  = int'(sensor_raw);
        grn   = (country_road == 2'b10) ? 1 : 0;
        old_x = m_x;
        if (m_lock != 0) begin
            if (m_lc == L - 1 && grn == 0) begin
                m_lock = 0;
                m_run  = 0;
            end else if (m_lc < L - 1) m_lc++;
        end else if (m_x != 0 && grn != 0 && m_g == M - 1) begin
            m_x = 0; m_lock = 1; m_lc = 0; m_run = 0;
        end else begin
            if (s != m_x) m_run++;
            else          m_run = 0;
            if (m_run == D + 1) begin
                m_x   = 1 - m_x;
                m_run = 0;
            end
        end
        if (grn == 0)                    m_g = 0;
        else if (old_x != 0 && m_g < M - 1) m_g++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int rise_edge;
        rst = 1'b1; sensor_raw = 1'b1; country_road = 2'b00;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (x !== 1'b0 || sensor_fault !== 1'b0)
                $display("FAIL reset_hold: x=%b fault=%b required x=0 fault=0", x, sensor_fault);
            else passed++;
        end
        rst = 1'b0;
        rise_edge = -1;
        for (int e = 0; e < 20; e++) begin
            tick();
            total++;
            if (x !== m_x[0]) $display("FAIL reset_rise_model: edge %0d x=%b required %0d", e, x, m_x);
            else passed++;
            if (x === 1'b1 && rise_edge < 0) rise_edge = e;
        end
        total++;
        if (rise_edge !== D + 2) $display("FAIL reset_rise_latency: edge %0d required %0d", rise_edge, D + 2);
        else passed++;
    endtask

    task automatic test_glitch_and_fall();
        int fall_edge;
        sensor_raw = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        sensor_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (x !== 1'b1 || m_x != 1) $display("FAIL low_dip: x=%b model=%0d required 1", x, m_x);
            else passed++;
        end
        sensor_raw = 1'b0; country_road = 2'b00;
        fall_edge = -1;
        for (int e = 0; e < 20; e++) begin
            tick();
            total++;
            if (x !== m_x[0]) $display("FAIL fall_model: edge %0d x=%b required %0d", e, x, m_x);
            else passed++;
            if (x === 1'b0 && fall_edge < 0) fall_edge = e;
        end
        total++;
        if (fall_edge !== D + 2) $display("FAIL fall_latency: edge %0d required %0d", fall_edge, D + 2);
        else passed++;
        sensor_raw = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sensor_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (x !== 1'b0 || m_x != 0) $display("FAIL high_glitch: x=%b model=%0d required 0", x, m_x);
            else passed++;
        end
    endtask

    task automatic test_max_green();
        int n;
        sensor_raw = 1'b1; country_road = 2'b00;
        n = 0;
        while (x !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        country_road = 2'b10;
        n = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            total++;
            if (x !== m_x[0]) $display("FAIL green_model: cycle %0d x=%b required %0d", e, x, m_x);
            else passed++;
            if (x === 1'b0 && n == 0) n = e;
        end
        total++;
        if (n !== M) $display("FAIL max_green_cut: cut after %0d green cycles required %0d", n, M);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (x !== 1'b0) $display("FAIL lockout_hold: x=%b required 0", x);
            else passed++;
        end
        country_road = 2'b00;
        n = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            total++;
            if (x !== m_x[0]) $display("FAIL rearm_model: edge %0d x=%b required %0d", e, x, m_x);
            else passed++;
            if (x === 1'b1 && n == 0) n = e;
        end
        total++;
        if (n !== D + 2) $display("FAIL rearm_latency: edge %0d required %0d", n, D + 2);
        else passed++;
    endtask

    task automatic test_async_reset();
        sensor_raw = 1'b0; country_road = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (x !== 1'b1 || m_x != 1) $display("FAIL drop_before_reset: x=%b model=%0d required 1", x, m_x);
        else passed++;
        #2 rst = 1'b1;
        #1;
        m_reset();
        total++;
        if (x !== 1'b0 || sensor_fault !== 1'b0)
            $display("FAIL async_reset: x=%b fault=%b required 0", x, sensor_fault);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (dut.cnt_q !== '0 || dut.gcnt_q !== '0 || dut.lcnt_q !== '0)
            $display("FAIL counters_after_reset: cnt=%0d gcnt=%0d lcnt=%0d required 0",
                     dut.cnt_q, dut.gcnt_q, dut.lcnt_q);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (x !== m_x[0]) $display("FAIL post_reset: x=%b required %0d", x, m_x);
            else passed++;
        end
    endtask

    task automatic test_random();
        int raw_left, cr_left;
        raw_left = 0; cr_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (raw_left == 0) begin
                sensor_raw = $urandom_range(0, 1) == 1;
                raw_left   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40))
                                                         : int'($urandom_range(1, 8));
            end
            if (cr_left == 0) begin
                country_road = 2'($urandom_range(0, 3));
                cr_left      = int'($urandom_range(1, 40));
            end
            raw_left--;
            cr_left--;
            tick();
            total++;
            if (x !== m_x[0] || sensor_fault !== 1'b0)
                $display("FAIL random: cycle %0d x=%b fault=%b required x=%0d fault=0",
                         i, x, sensor_fault, m_x);
            else passed++;
        end
    endtask

`ifdef SENSOR_STUCK_DETECT_EN
    task automatic test_stuck();
        rst = 1'b1; tick(); rst = 1'b0;
        sensor_raw = 1'b1; country_road = 2'b00;
        for (int i = 0; i < 70; i++) tick();
        total++;
        if (sensor_fault !== 1'b1 || x !== 1'b0)
            $display("FAIL stuck_set: fault=%b x=%b required fault=1 x=0", sensor_fault, x);
        else passed++;
        sensor_raw = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (sensor_fault !== 1'b0) $display("FAIL stuck_clear: fault=%b required 0", sensor_fault);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_glitch_and_fall();
        test_max_green();
        test_async_reset();
        test_random();
`ifdef SENSOR_STUCK_DETECT_EN
        test_stuck();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
